// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: single write-port arbiter in front of a register file.
// Pipeline writeback always wins; a debug/loader port takes the leftover slots
// through a valid/ready handshake. A starvation counter raises stall_req so the
// pipeline can yield a slot to debug.
// Optional feature macro: RF_CLEAR_EN -- when defined, every reset is followed
// by a one-shot sweep that zeroes x1..x31 before normal arbitration starts.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        dbg_valid,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        dbg_ready,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        busy,
  output logic        stall_req
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic        w_sweep;      // clear sweep owns the write port this cycle
  logic [4:0]  w_sweep_idx;  // register being zeroed by the sweep
  logic        w_wb_hit;
  logic        w_hs;
  logic        w_we_nxt;
  logic [4:0]  w_a3_nxt;
  logic [31:0] w_wd_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_stall;
  logic        r_we;
  logic [4:0]  r_a3;
  logic [31:0] r_wd;

`ifdef RF_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_idx, w_idx_nxt;

  // Sweep state register; reset always restarts the sweep at x1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_idx   <= 5'd1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sweep advances one register per cycle and leaves for RUN after x31;
  // the index holds at 31 afterwards so the sweep never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == S_CLEAR) begin
      if (r_idx == 5'd31) w_state_nxt = S_RUN;
      else                w_idx_nxt   = r_idx + 5'd1;
    end
  end

  assign w_sweep     = (r_state == S_CLEAR);
  assign w_sweep_idx = r_idx;
`else
  assign w_sweep     = 1'b0;
  assign w_sweep_idx = 5'd0;
`endif

  // A writeback to x0 is a no-op and must not steal the slot from debug.
  assign w_wb_hit  = wb_we && (wb_addr != 5'd0);
  assign dbg_ready = dbg_valid && !w_wb_hit && !w_sweep;
  assign w_hs      = dbg_valid && dbg_ready;

  // Next write-port value: sweep, then writeback, then debug; otherwise the
  // strobe drops and address/data hold.
  always_comb begin
    w_we_nxt = 1'b0;
    w_a3_nxt = r_a3;
    w_wd_nxt = r_wd;
    if (w_sweep) begin
      w_we_nxt = 1'b1;
      w_a3_nxt = w_sweep_idx;
      w_wd_nxt = 32'd0;
    end else if (w_wb_hit) begin
      w_we_nxt = 1'b1;
      w_a3_nxt = wb_addr;
      w_wd_nxt = wb_data;
    end else if (w_hs && (dbg_addr != 5'd0)) begin
      w_we_nxt = 1'b1;
      w_a3_nxt = dbg_addr;
      w_wd_nxt = dbg_data;
    end
  end

  // Starvation counter: counts denied debug cycles, saturates at the limit.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!dbg_valid || dbg_ready) w_cnt_nxt = 4'd0;
    else if (r_cnt != LIM)       w_cnt_nxt = r_cnt + 4'd1;
  end

  // Registered write port, counter and stall request. The stall sets once the
  // counter sits at the limit and debug is still being denied, and drops on
  // the edge after a handshake or after debug withdraws.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_a3    <= 5'd0;
      r_wd    <= 32'd0;
      r_cnt   <= 4'd0;
      r_stall <= 1'b0;
    end else begin
      r_we    <= w_we_nxt;
      r_a3    <= w_a3_nxt;
      r_wd    <= w_wd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stall <= (r_cnt == LIM) && dbg_valid && !dbg_ready;
    end
  end

  assign rf_we     = r_we;
  assign rf_a3     = r_a3;
  assign rf_wd3    = r_wd;
  assign stall_req = r_stall;
  assign busy      = w_sweep;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; covers the clear sweep when built
// with RF_CLEAR_EN, and RUN-mode arbitration, starvation and reset otherwise.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        busy;
  logic        stall_req;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_ready(dbg_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .busy(busy), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    dbg_valid = 1'b0; dbg_addr = 5'd0; dbg_data = 32'd0;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a3, input logic [31:0] wd);
    chk({tag, ".we"}, 32'(rf_we), 32'(we));
    chk({tag, ".a3"}, 32'(rf_a3), 32'(a3));
    chk({tag, ".wd"}, rf_wd3, wd);
  endtask

`ifdef RF_CLEAR_EN
  // Run a whole sweep from index 1, checking each edge.
  task automatic sweep_full();
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk_wr($sformatf("sweep%0d", k), 1'b1, 5'(k), 32'd0);
      chk($sformatf("sweep_busy%0d", k), 32'(busy), (k < 31) ? 32'd1 : 32'd0);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    chk_wr("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.stall", 32'(stall_req), 32'd0);
`ifdef RF_CLEAR_EN
    chk("reset.busy", 32'(busy), 32'd1);
    dbg_valid = 1'b1; dbg_addr = 5'd2;
    #1;
    chk("clear.ready", 32'(dbg_ready), 32'd0);
    dbg_valid = 1'b0;
    rst = 1'b0;
    // wb inputs are ignored during the sweep
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    sweep_full();
    wb_we = 1'b0;
`else
    chk("reset.busy", 32'(busy), 32'd0);
    rst = 1'b0;
`endif

    // ready follows valid once in RUN
    dbg_valid = 1'b1; dbg_addr = 5'd0;
    #1;
    chk("run.ready", 32'(dbg_ready), 32'd1);
    dbg_valid = 1'b0;
    tick();
    chk("run.idle_we", 32'(rf_we), 32'd0);

    // same address collision: writeback first, debug next
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    dbg_valid = 1'b1; dbg_addr = 5'd5; dbg_data = 32'h12;
    #1;
    chk("coll.ready0", 32'(dbg_ready), 32'd0);
    tick();
    chk_wr("coll.e1", 1'b1, 5'd5, 32'hDEADBEEF);
    wb_we = 1'b0;
    #1;
    chk("coll.ready1", 32'(dbg_ready), 32'd1);
    tick();
    chk_wr("coll.e2", 1'b1, 5'd5, 32'h12);
    idle_inputs();

    // nothing granted: strobe drops, address/data hold
    tick();
    chk_wr("hold", 1'b0, 5'd5, 32'h12);

    // writeback to x0 does not block debug
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hAAAA;
    dbg_valid = 1'b1; dbg_addr = 5'd3; dbg_data = 32'h7;
    #1;
    chk("x0wb.ready", 32'(dbg_ready), 32'd1);
    tick();
    chk_wr("x0wb", 1'b1, 5'd3, 32'h7);
    idle_inputs();

    // debug write to x0: handshake, no strobe
    dbg_valid = 1'b1; dbg_addr = 5'd0; dbg_data = 32'hFF;
    #1;
    chk("dbgx0.ready", 32'(dbg_ready), 32'd1);
    tick();
    chk_wr("dbgx0", 1'b0, 5'd3, 32'h7);
    idle_inputs();

    // starvation released by handshake
    wb_we = 1'b1; wb_addr = 5'd9;
    dbg_valid = 1'b1; dbg_addr = 5'd4; dbg_data = 32'h44;
    for (int c = 1; c <= 5; c++) begin
      wb_data = 32'(c);
      tick();
      chk($sformatf("starve.stall%0d", c), 32'(stall_req), (c < 5) ? 32'd0 : 32'd1);
      chk_wr($sformatf("starve.wb%0d", c), 1'b1, 5'd9, 32'(c));
    end
    wb_we = 1'b0;
    #1;
    chk("starve.ready", 32'(dbg_ready), 32'd1);
    tick();
    chk("starve.release", 32'(stall_req), 32'd0);
    chk_wr("starve.dbg", 1'b1, 5'd4, 32'h44);
    idle_inputs();

    // starvation released by debug withdrawing
    wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h10;
    dbg_valid = 1'b1; dbg_addr = 5'd6;
    for (int c = 1; c <= 5; c++) tick();
    chk("wd.stall", 32'(stall_req), 32'd1);
    dbg_valid = 1'b0;
    tick();
    chk("wd.release", 32'(stall_req), 32'd0);
    chk_wr("wd.wb", 1'b1, 5'd10, 32'h10);

    // reset mid-RUN cancels an in-flight strobe
    wb_addr = 5'd7; wb_data = 32'h77;
    tick();
    chk("midrun.we", 32'(rf_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk_wr("midrun.rst", 1'b0, 5'd0, 32'd0);
    idle_inputs();
    #2 rst = 1'b0;

`ifdef RF_CLEAR_EN
    // reset at sweep index 17 restarts the sweep at x1
    for (int k = 1; k <= 17; k++) tick();
    chk("mid.a3", 32'(rf_a3), 32'd17);
    #1 rst = 1'b1;
    #1;
    chk_wr("midsweep.rst", 1'b0, 5'd0, 32'd0);
    chk("midsweep.busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    sweep_full();
`else
    tick();
    chk_wr("postrst", 1'b0, 5'd0, 32'd0);
    chk("postrst.busy", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
